// File: rtl/fetch_queue.sv
// fetch_queue: fetch-address generator, synchronous-ROM issue and DEPTH-entry PC/instruction queue.
// Define FETCHQ_DELAY_SLOT_EN to preserve the MIPS branch delay slot on redirect.
module fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_i,
    input  logic                       redirect_i,
    input  logic [ADDR_W-1:0]          redirect_pc_i,
    output logic                       rom_ce,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [INST_W-1:0]          rom_data,
    output logic                       valid_o,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int             CNT_W   = $clog2(DEPTH+1);
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  head_n;
    logic [CNT_W-1:0]  count;
    logic              inflight;
    logic              squash;

    logic              pop;
    logic              issue;
    logic              push;
    logic              flush;
    logic              keep_one;
    logic              squash_n;
    logic [CNT_W:0]    credit;
    logic [ADDR_W-1:0] fetch_pc_n;

`ifdef FETCHQ_DELAY_SLOT_EN
    logic              pending;
    logic              pending_n;
    logic [ADDR_W-1:0] pending_pc;
    logic [ADDR_W-1:0] pending_pc_n;
`endif

    // Credit counts queued entries plus the return in flight, so a full queue never overflows.
    assign valid_o  = rst && (count != '0);
    assign pop      = valid_o && !stall_i;
    assign credit   = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign issue    = rst && (credit < DEPTH_C);
    assign rom_ce   = issue;
    assign rom_addr = fetch_pc;
    assign inst_o   = valid_o ? inst_mem[rd_ptr] : '0;
    assign pc_o     = valid_o ? pc_mem[rd_ptr] : '0;
    assign count_o  = rst ? count : '0;
    assign head_n   = rd_ptr + PTR_W'(pop);

    always_comb begin
        push       = inflight && !squash;
        flush      = 1'b0;
        keep_one   = 1'b0;
        squash_n   = 1'b0;
        fetch_pc_n = issue ? fetch_pc + ADDR_W'(4) : fetch_pc;
`ifdef FETCHQ_DELAY_SLOT_EN
        pending_n    = pending;
        pending_pc_n = pending_pc;
        if (pending && issue) begin
            fetch_pc_n = pending_pc;
            pending_n  = 1'b0;
        end
        // The delay slot is the oldest survivor: a queued entry, else the arriving return, else the request now.
        if (redirect_i && pending) begin
            pending_pc_n = redirect_pc_i;
            if (issue) fetch_pc_n = redirect_pc_i;
        end else if (redirect_i) begin
            if (count != CNT_W'(pop)) begin
                keep_one   = 1'b1;
                push       = 1'b0;
                squash_n   = issue;
                fetch_pc_n = redirect_pc_i;
            end else if (push) begin
                squash_n   = issue;
                fetch_pc_n = redirect_pc_i;
            end else if (issue) begin
                fetch_pc_n = redirect_pc_i;
            end else begin
                pending_n    = 1'b1;
                pending_pc_n = redirect_pc_i;
            end
        end
`else
        if (redirect_i) begin
            flush      = 1'b1;
            push       = 1'b0;
            squash_n   = issue;
            fetch_pc_n = redirect_pc_i;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            squash   <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_n;
            inflight <= issue;
            squash   <= squash_n;
            if (issue) req_pc <= fetch_pc;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else if (keep_one) begin
                rd_ptr <= head_n;
                wr_ptr <= head_n + PTR_W'(1);
                count  <= CNT_W'(1);
            end else begin
                rd_ptr <= head_n;
                wr_ptr <= wr_ptr + PTR_W'(push);
                count  <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

`ifdef FETCHQ_DELAY_SLOT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending    <= 1'b0;
            pending_pc <= RESET_PC;
        end else begin
            pending    <= pending_n;
            pending_pc <= pending_pc_n;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst && push) begin
            inst_mem[wr_ptr] <= rom_data;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench with a behavioural synchronous ROM and an expected-PC scoreboard.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [2:0]  count_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .rom_ce(rom_ce), .rom_addr(rom_addr),
        .rom_data(rom_data), .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o),
        .count_o(count_o)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) if (rom_ce) rom_data <= rom_word(rom_addr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] target);
        stall_i       = stall;
        redirect_i    = redir;
        redirect_pc_i = target;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release decode until every expected PC has been popped, then stall again.
    task automatic drain(input string tag);
        int budget = 40;
        stall_i = 1'b0;
        while (sb.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        stall_i = 1'b1;
        checkOutput({tag, " drained"}, sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (valid_o && !stall_i) begin
            n_checks++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("[TB] FAIL unexpected_pop observed pc_o=%0h expected none", pc_o);
            end
            if (sb.size() > 0) begin
                exp_pc = sb.pop_front();
                checkOutput("pop pc_o", pc_o, exp_pc);
                checkOutput("pop inst_o", inst_o, rom_word(exp_pc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset rom_ce", rom_ce, 0);
        checkOutput("reset valid_o", valid_o, 0);
        checkOutput("reset count_o", count_o, 0);
        checkOutput("reset inst_o", inst_o, 0);
        checkOutput("reset pc_o", pc_o, 0);

        // Reset release and streaming issue, then ten stalled cycles.
        tick(); rst = 1'b1;
        @(negedge clk);
        checkOutput("c0 rom_ce", rom_ce, 1);
        checkOutput("c0 rom_addr", rom_addr, 32'h0);
        tick();
        @(negedge clk);
        checkOutput("c1 rom_addr", rom_addr, 32'h4);
        tick(); applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("c2 valid_o", valid_o, 1);
        checkOutput("c2 pc_o", pc_o, 32'h0);
        checkOutput("c2 inst_o", inst_o, rom_word(32'h0));
        checkOutput("c2 rom_addr", rom_addr, 32'h8);
        repeat (9) tick();
        @(negedge clk);
        checkOutput("stall count_o", count_o, 4);
        checkOutput("stall rom_ce", rom_ce, 0);
        checkOutput("stall pc_o", pc_o, 32'h0);
        tick();
        for (int i = 0; i < 6; i++) sb.push_back(32'(i * 4));
        drain("stall release");

        // Reset with a full queue, then redirect in the first cycle after release.
        repeat (4) tick();
        @(negedge clk);
        checkOutput("full count_o", count_o, 4);
        checkOutput("full rom_ce", rom_ce, 0);
        tick(); rst = 1'b0;
        @(negedge clk);
        checkOutput("rst valid_o", valid_o, 0);
        checkOutput("rst count_o", count_o, 0);
        checkOutput("rst rom_ce", rom_ce, 0);
        checkOutput("rst inst_o", inst_o, 0);
        tick(); rst = 1'b1; applyStimulus(1'b0, 1'b1, 32'h200);
        @(negedge clk);
        checkOutput("rel count_o", count_o, 0);
        checkOutput("rel valid_o", valid_o, 0);
        checkOutput("rel rom_ce", rom_ce, 1);
        checkOutput("rel rom_addr", rom_addr, 32'h0);
        tick(); applyStimulus(1'b0, 1'b0, 32'h0);
`ifdef FETCHQ_DELAY_SLOT_EN
        sb.push_back(32'h0);
`endif
        sb.push_back(32'h200);
        sb.push_back(32'h204);
        @(negedge clk);
        checkOutput("rel target rom_addr", rom_addr, 32'h200);
        tick();
        drain("early redirect");

        // Redirect with three entries queued and a return outstanding.
        tick(); rst = 1'b0;
        tick(); rst = 1'b1; applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (4) tick(); applyStimulus(1'b1, 1'b1, 32'h100);
        @(negedge clk);
        checkOutput("q3 count_o", count_o, 3);
        checkOutput("q3 rom_ce", rom_ce, 0);
        tick(); applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("q3 rom_addr", rom_addr, 32'h100);
        checkOutput("q3 rom_ce next", rom_ce, 1);
`ifdef FETCHQ_DELAY_SLOT_EN
        checkOutput("q3 count_o next", count_o, 1);
        tick();
        @(negedge clk);
        checkOutput("q3 slot pc_o", pc_o, 32'h0);
        tick();
        @(negedge clk);
        checkOutput("q3 slot hold pc_o", pc_o, 32'h0);
        sb.push_back(32'h0);
`else
        checkOutput("q3 count_o next", count_o, 0);
        tick();
        @(negedge clk);
        checkOutput("q3 bubble valid_o", valid_o, 0);
        tick();
        @(negedge clk);
        checkOutput("q3 target valid_o", valid_o, 1);
        checkOutput("q3 target pc_o", pc_o, 32'h100);
`endif
        sb.push_back(32'h100);
        sb.push_back(32'h104);
        tick();
        drain("flush redirect");

        // Branch at 0x8 popped while 0xC sits behind it.
        tick(); rst = 1'b0;
        tick(); rst = 1'b1; applyStimulus(1'b0, 1'b0, 32'h0);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
`ifdef FETCHQ_DELAY_SLOT_EN
        sb.push_back(32'hC);
`endif
        sb.push_back(32'h40);
        sb.push_back(32'h44);
        repeat (4) tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("br head pc_o", pc_o, 32'h8);
        checkOutput("br count_o", count_o, 1);
        tick(); applyStimulus(1'b0, 1'b1, 32'h40);
        @(negedge clk);
        checkOutput("br redirect count_o", count_o, 2);
        tick(); applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("br rom_addr", rom_addr, 32'h40);
        tick();
        drain("branch");

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
